// File: rtl/mux2t1_4.sv
// 2:1 word multiplexer with a combinational output and a registered copy.
// Optional macro MUX2T1_PARITY_EN adds a registered even-parity output o_par.
module mux2t1_4 #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] o,
`ifdef MUX2T1_PARITY_EN
   output logic             o_par,
`endif
   output logic [WIDTH-1:0] o_q,
   output logic             sel_q,
   output logic             o_vld
);

   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
         $error("mux2t1_4: WIDTH must be in 1..32");
      end
   endgenerate

   // Plain ternary keeps standard X propagation when sel is unknown.
   assign o = sel ? b : a;

   logic [WIDTH-1:0] o_d;
   logic             sel_d;
   logic             vld_d;
   logic             vld_q;

   always_comb begin
      o_d   = o_q;
      sel_d = sel_q;
      vld_d = vld_q;
      if (en) begin
         o_d   = o;
         sel_d = sel;
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q   <= RST_VAL;
         sel_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         o_q   <= o_d;
         sel_q <= sel_d;
         vld_q <= vld_d;
      end
   end

   assign o_vld = vld_q;

`ifdef MUX2T1_PARITY_EN
   logic par_d;
   logic par_q;

   always_comb begin
      par_d = par_q;
      if (en) begin
         par_d = ^o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= ^RST_VAL;
      end else begin
         par_q <= par_d;
      end
   end

   assign o_par = par_q;
`endif

endmodule

// File: tb/tb_mux2t1_4.sv
// Directed table-driven bench for mux2t1_4, plus hand sequences for
// asynchronous reset and o_vld behaviour.
module tb_mux2t1_4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       sel;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] o;
   logic [3:0] o_q;
   logic       sel_q;
   logic       o_vld;
`ifdef MUX2T1_PARITY_EN
   logic       o_par;
`endif

   int checks = 0;
   int errors = 0;

   mux2t1_4 #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .sel   (sel),
      .a     (a),
      .b     (b),
      .o     (o),
`ifdef MUX2T1_PARITY_EN
      .o_par (o_par),
`endif
      .o_q   (o_q),
      .sel_q (sel_q),
      .o_vld (o_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       sel;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp_o;
      logic [3:0] exp_oq;
      logic       exp_selq;
      logic       exp_vld;
      logic       exp_par;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      //           en    sel   a        b        o        o_q      selq  vld   par
      vecs[0] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 4'b1010, 4'b0001, 4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 4'b1010, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 4'b1111, 4'b0001, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 4'b1111, 4'b0110, 4'b0110, 4'b0001, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 4'b1111, 4'b0110, 4'b0110, 4'b0110, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 4'b0101, 4'b1100, 4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 4'b1111, 4'b0111, 4'b0111, 4'b0111, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 4'b1011, 4'b0000, 4'b1011, 4'b1011, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0;
      en    = 1'b0;
      sel   = 1'b0;
      a     = 4'b0000;
      b     = 4'b0000;

      // Reset state, held across a clock edge
      #2;
      chk("rst_o_q",   32'(o_q),   32'h0);
      chk("rst_sel_q", 32'(sel_q), 32'h0);
      chk("rst_o_vld", 32'(o_vld), 32'h0);
      @(posedge clk); #1;
      chk("rst_hold_o_vld", 32'(o_vld), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;

      for (int i = 0; i < 9; i++) begin
         en  = vecs[i].en;
         sel = vecs[i].sel;
         a   = vecs[i].a;
         b   = vecs[i].b;
         #1;
         chk($sformatf("v%0d_o", i), 32'(o), 32'(vecs[i].exp_o));
         @(posedge clk); #1;
         chk($sformatf("v%0d_o_q", i),   32'(o_q),   32'(vecs[i].exp_oq));
         chk($sformatf("v%0d_sel_q", i), 32'(sel_q), 32'(vecs[i].exp_selq));
         chk($sformatf("v%0d_o_vld", i), 32'(o_vld), 32'(vecs[i].exp_vld));
`ifdef MUX2T1_PARITY_EN
         chk($sformatf("v%0d_o_par", i), 32'(o_par), 32'(vecs[i].exp_par));
`endif
         #1;
      end

      // Asynchronous reset pulsed between edges, mid-operation
      en  = 1'b1;
      sel = 1'b1;
      a   = 4'b0011;
      b   = 4'b1001;
      @(posedge clk); #1;
      chk("pre_rst_o_q", 32'(o_q), 32'h9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_o_q",   32'(o_q),   32'h0);
      chk("async_sel_q", 32'(sel_q), 32'h0);
      chk("async_o_vld", 32'(o_vld), 32'h0);
      chk("async_o",     32'(o),     32'h9);
`ifdef MUX2T1_PARITY_EN
      chk("async_o_par", 32'(o_par), 32'h0);
`endif
      @(posedge clk); #1;
      chk("rst_low_edge_o_q",   32'(o_q),   32'h0);
      chk("rst_low_edge_o_vld", 32'(o_vld), 32'h0);
      sel = 1'b0;
      #1;
      chk("rst_low_o_follows", 32'(o), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;

      // en=0 after reset: o_vld must stay low and o_q keep the reset value
      @(posedge clk); #1;
      chk("en0_post_rst_o_vld", 32'(o_vld), 32'h0);
      chk("en0_post_rst_o_q",   32'(o_q),   32'h0);
      #1;
      en = 1'b1;
      @(posedge clk); #1;
      chk("first_cap_o_vld", 32'(o_vld), 32'h1);
      chk("first_cap_o_q",   32'(o_q),   32'h3);
      chk("first_cap_sel_q", 32'(sel_q), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux2t1_4.md
Name: mux2t1_4

Overview:
- 2:1 multiplexer for 4-bit data words (WIDTH-parameterised, default 4) with a combinational output and a registered output.
- sel=0 routes a; sel=1 routes b.
- Used as a small datapath steering element in the lab datapath. The combinational path serves same-cycle consumers; the registered copy serves timing-closed pipeline stages.

Parameters:
- WIDTH, 4, bit width of a, b, o, o_q (legal range 1..32)
- RST_VAL, 0, value loaded into o_q on reset (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable for registered output
- sel  input  1  select: 0 -> a, 1 -> b
- a  input  WIDTH  data input 0
- b  input  WIDTH  data input 1
- o  output  WIDTH  combinational mux output
- o_q  output  WIDTH  registered mux output
- sel_q  output  1  sel value captured with o_q
- o_vld  output  1  high once o_q holds a captured (non-reset) value

Behaviour:
- o = sel ? b : a, purely combinational, zero latency.
  - Depends only on sel/a/b; unaffected by clk, rst_n, en.
  - X/Z on sel: o follows standard ternary semantics (bitwise X where a and b differ). No extra filtering.
- rst_n low (asynchronous, any time, including mid-operation):
  - o_q = RST_VAL
  - sel_q = 0
  - o_vld = 0
  - These values hold while rst_n stays low.
- Reset release: synchronous deassertion assumed at the system level. The first rising edge with rst_n high is a normal cycle.
- Rising clk with rst_n high and en=1:
  - o_q <= (sel ? b : a)
  - sel_q <= sel
  - o_vld <= 1
  - Latency from input to o_q is 1 cycle.
- Rising clk with en=0: o_q, sel_q, o_vld hold their values.
- o_vld is sticky high until the next reset.
- Simultaneous change of sel and data in the same cycle: o_q reflects the values present at the capturing edge. No glitch filtering on o.
- No state machine. Only a single register stage of WIDTH+2 bits (+1 with the optional feature).
- Implementation structure:
  - Combinational mux as a per-bit generate loop or assign.
  - Register block with async clear.
  - Parameter legality check at elaboration: report an error if WIDTH < 1 or WIDTH > 32.

Optional Feature:
- Macro MUX2T1_PARITY_EN.
- Defined: adds output o_par (1 bit).
  - o_par is the registered even parity (XOR reduction) of the selected word.
  - Updated on the same edge and under the same en condition as o_q.
  - Reset value is the XOR reduction of RST_VAL (0 for the default RST_VAL).
- Undefined: port o_par and its register are absent. All other behaviour is identical.

Test Plan:
- a=0, b=0, sel=0, en=1 for 100 ns -> o=0000, o_q=0000. o_vld rises after the first clock edge.
- a=1010, b=0001, sel=0 -> o=1010 immediately. o_q=1010 and sel_q=0 after 1 clock.
- Same data, sel switched to 1 -> o=0001 in the same cycle. o_q=0001 and sel_q=1 one clock later.
- en=0, then sel toggled and a changed to 1111 -> o tracks the inputs immediately. o_q and sel_q hold their last values (0001 / 1).
- rst_n pulsed low between clock edges -> o_q=0000, sel_q=0, o_vld=0 immediately, without waiting for clk. o stays sel ? b : a throughout.
- With MUX2T1_PARITY_EN, sel=0, a=1010 -> o_par=0 after 1 clock. sel=1, b=0001 -> o_par=1 after 1 clock.
